// File: rtl/axi_inst_mem_responder_pkg.sv
// AXI encodings, responder FSM states and the shared burst address generator.
// Imported by the instruction-memory responder and any future AXI master/slave.
package axi_inst_mem_responder_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } axi_burst_e;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRead,
        StResp
    } resp_state_e;

    localparam int unsigned AxiAddrW = 32;
    localparam int unsigned AxiDataW = 32;

    // Address of the beat following 'addr' within a burst, 32-bit wrap-around arithmetic.
    function automatic logic [AxiAddrW-1:0] next_beat_addr(
        input logic [AxiAddrW-1:0] addr,
        input logic [2:0]          size,
        input logic [7:0]          len,
        input logic [1:0]          burst
    );
        logic [AxiAddrW-1:0] step;
        logic [AxiAddrW-1:0] incr;
        logic [AxiAddrW-1:0] win_mask;
        logic [AxiAddrW-1:0] result;
        step = 32'd1 << size;
        incr = addr + step;
        // Legal WRAP lengths make the (len+1)*step window a power of two.
        win_mask = (({24'd0, len} + 32'd1) * step) - 32'd1;
        case (burst)
            BurstFixed: result = addr;
            BurstWrap:  result = (addr & ~win_mask) | (incr & win_mask);
            default:    result = incr;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/axi_inst_mem_responder.sv
// AXI4 read-only responder for the instruction-fetch path, backed by a synchronous
// word SRAM with one cycle of read latency and an optional fixed access delay.
module axi_inst_mem_responder
    import axi_inst_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 16,
    parameter int unsigned LATENCY    = 0,
    parameter int unsigned ID_W       = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [31:0]           araddr,
    input  logic [ID_W-1:0]       arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic [ID_W-1:0]       rid,
    output logic                  mem_en,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    input  logic [31:0]           mem_rdata
);

    localparam logic [32:0] MemBytes   = 33'd4 << DEPTH_LOG2;
    localparam logic [7:0]  LatencyCnt = 8'(LATENCY);

    resp_state_e state;
    axi_resp_e   resp_q;
    axi_resp_e   ar_resp;
    axi_resp_e   nxt_resp;
    logic [31:0] addr_q;
    logic [31:0] nxt_addr;
    logic [7:0]  len_q;
    logic [7:0]  beat_q;
    logic [7:0]  delay_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        capture_q;
    logic [31:0] rdata_q;
    logic [31:0] beat_data;

    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return !off[32] && (off < MemBytes);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return DEPTH_LOG2'(off >> 2);
    endfunction

    always_comb begin
        ar_resp = RespOkay;
        if (!in_range(araddr)) begin
            ar_resp = RespDecerr;
        end else if (arsize > 3'd2 || arburst == BurstRsvd) begin
            ar_resp = RespSlverr;
        end else if (arburst == BurstWrap &&
                     !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15)) begin
            ar_resp = RespSlverr;
        end
    end

    // A healthy burst that walks off the top of the SRAM turns DECERR for the rest of it.
    always_comb begin
        nxt_addr = next_beat_addr(addr_q, size_q, len_q, burst_q);
        nxt_resp = resp_q;
        if (resp_q == RespOkay && !in_range(nxt_addr)) begin
            nxt_resp = RespDecerr;
        end
    end

    // SRAM data only exists in the first RESP cycle, so it is forwarded then and held after.
    assign beat_data = (resp_q == RespOkay) ? mem_rdata : 32'd0;
    assign rdata     = capture_q ? beat_data : rdata_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rlast     <= 1'b0;
            rresp     <= 2'b00;
            rid       <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            resp_q    <= RespOkay;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            delay_q   <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            capture_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            mem_en    <= 1'b0;
            capture_q <= 1'b0;
            if (capture_q) begin
                rdata_q <= beat_data;
            end
            case (state)
                StIdle: begin
                    if (arready && arvalid) begin
                        arready <= 1'b0;
                        addr_q  <= araddr;
                        len_q   <= arlen;
                        size_q  <= arsize;
                        burst_q <= arburst;
                        rid     <= arid;
                        beat_q  <= '0;
                        resp_q  <= ar_resp;
                        if (LATENCY != 0) begin
                            state   <= StDelay;
                            delay_q <= LatencyCnt;
                        end else begin
                            state    <= StRead;
                            mem_en   <= (ar_resp == RespOkay);
                            mem_addr <= word_index(araddr);
                        end
                    end else begin
                        arready <= 1'b1;
                    end
                end
                StDelay: begin
                    if (delay_q <= 8'd1) begin
                        state    <= StRead;
                        mem_en   <= (resp_q == RespOkay);
                        mem_addr <= word_index(addr_q);
                    end else begin
                        delay_q <= delay_q - 8'd1;
                    end
                end
                StRead: begin
                    state     <= StResp;
                    rvalid    <= 1'b1;
                    rlast     <= (beat_q == len_q);
                    rresp     <= resp_q;
                    capture_q <= 1'b1;
                end
                StResp: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            state   <= StIdle;
                            arready <= 1'b1;
                        end else begin
                            state    <= StRead;
                            beat_q   <= beat_q + 8'd1;
                            addr_q   <= nxt_addr;
                            resp_q   <= nxt_resp;
                            mem_en   <= (nxt_resp == RespOkay);
                            mem_addr <= word_index(nxt_addr);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_inst_mem_responder.sv
// Bench for axi_inst_mem_responder: a zero-latency and a five-cycle-latency instance
// share the AR/R stimulus and are checked against a closed-form burst model.
module tb_axi_inst_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          ID_W  = 4;
    localparam logic [31:0] BYTES = 32'h0004_0000;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, sel, arvalid, rready;
    logic [31:0] araddr;
    logic [ID_W-1:0] arid;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;

    logic arready_0, rvalid_0, rlast_0, mem_en_0, arready_5, rvalid_5, rlast_5, mem_en_5;
    logic [31:0] rdata_0, mem_rdata_0, rdata_5, mem_rdata_5;
    logic [1:0] rresp_0, rresp_5;
    logic [ID_W-1:0] rid_0, rid_5;
    logic [15:0] mem_addr_0, mem_addr_5;

    logic [31:0] mem [65536];

    axi_inst_mem_responder #(.BASE(BASE), .DEPTH_LOG2(16), .LATENCY(0), .ID_W(ID_W)) u_dut0 (
        .clock(clock), .reset(reset), .arvalid(arvalid && !sel), .arready(arready_0),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_0), .rready(rready), .rdata(rdata_0), .rresp(rresp_0), .rlast(rlast_0),
        .rid(rid_0), .mem_en(mem_en_0), .mem_addr(mem_addr_0), .mem_rdata(mem_rdata_0)
    );

    axi_inst_mem_responder #(.BASE(BASE), .DEPTH_LOG2(16), .LATENCY(5), .ID_W(ID_W)) u_dut5 (
        .clock(clock), .reset(reset), .arvalid(arvalid && sel), .arready(arready_5),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid_5), .rready(rready), .rdata(rdata_5), .rresp(rresp_5), .rlast(rlast_5),
        .rid(rid_5), .mem_en(mem_en_5), .mem_addr(mem_addr_5), .mem_rdata(mem_rdata_5)
    );

    always @(posedge clock) begin
        if (mem_en_0) mem_rdata_0 <= mem[mem_addr_0];
        if (mem_en_5) mem_rdata_5 <= mem[mem_addr_5];
    end

    logic o_arready, o_rvalid, o_rlast, o_mem_en;
    logic [31:0] o_rdata;
    logic [1:0] o_rresp;
    logic [ID_W-1:0] o_rid;
    logic [15:0] o_mem_addr;
    assign o_arready  = sel ? arready_5  : arready_0;
    assign o_rvalid   = sel ? rvalid_5   : rvalid_0;
    assign o_rlast    = sel ? rlast_5    : rlast_0;
    assign o_mem_en   = sel ? mem_en_5   : mem_en_0;
    assign o_rdata    = sel ? rdata_5    : rdata_0;
    assign o_rresp    = sel ? rresp_5    : rresp_0;
    assign o_rid      = sel ? rid_5      : rid_0;
    assign o_mem_addr = sel ? mem_addr_5 : mem_addr_0;

    logic [15:0] memq[$];
    always @(negedge clock) if (o_mem_en) memq.push_back(o_mem_addr);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit in_range_m(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < BYTES);
    endfunction

    function automatic logic [15:0] word_of(input logic [31:0] a);
        return 16'((a - BASE) >> 2);
    endfunction

    // Model: every beat address in closed form from the burst start, plus its response.
    logic [31:0] exp_addr [256];
    logic [1:0]  exp_resp [256];

    task automatic build_model(input logic [31:0] a, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, win, wbase, bb;
        logic [1:0] r;
        step = 32'd1 << size;
        win  = (32'(len) + 32'd1) * step;
        if (!in_range_m(a)) r = DECERR;
        else if (size > 3'd2 || burst == 2'b11) r = SLVERR;
        else if (burst == WRAP && !(len == 1 || len == 3 || len == 7 || len == 15)) r = SLVERR;
        else r = OKAY;
        for (int b = 0; b <= int'(len); b++) begin
            bb = 32'(b);
            if (burst == FIXED) exp_addr[b] = a;
            else if (burst == WRAP) begin
                wbase = a - (a % win);
                exp_addr[b] = wbase + (((a - wbase) + bb * step) % win);
            end else exp_addr[b] = a + bb * step;
            if (r == OKAY && !in_range_m(exp_addr[b])) r = DECERR;
            exp_resp[b] = r;
        end
    endtask

    task automatic check_beat(input logic [31:0] ed, input logic [1:0] er, input logic el,
                              input logic [ID_W-1:0] id);
        check("rvalid", 32'(o_rvalid), 32'd1);
        check("rdata", o_rdata, ed);
        check("rresp", 32'(o_rresp), 32'(er));
        check("rlast", 32'(o_rlast), 32'(el));
        check("rid", 32'(o_rid), 32'(id));
        check("mem_en_in_resp", 32'(o_mem_en), 32'd0);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [ID_W-1:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall_lo,
                           input int stall_hi, input int lat, output logic [1:0] first_resp,
                           output logic [31:0] first_data);
        logic [15:0] exp_words[$];
        logic [31:0] ed;
        int cyc, busy_hi, stall;
        build_model(a, len, size, burst);
        for (int b = 0; b <= int'(len); b++)
            if (exp_resp[b] == OKAY) exp_words.push_back(word_of(exp_addr[b]));
        first_resp = 2'b01;
        first_data = 32'd0;
        @(negedge clock);
        araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1; rready = 1'b0;
        memq.delete();
        check("arready_idle", 32'(o_arready), 32'd1);
        @(negedge clock);
        arvalid = 1'b0;
        cyc = 1;
        busy_hi = 0;
        for (int b = 0; b <= int'(len); b++) begin
            while (!o_rvalid && cyc < 4000) begin
                if (o_arready) busy_hi++;
                @(negedge clock);
                cyc++;
            end
            if (!o_rvalid) begin
                n_tests++;
                n_fail++;
                $display("FAIL rvalid_timeout: beat %0d never valid within %0d cycles", b, cyc);
                return;
            end
            if (b == 0) begin
                check("first_beat_cycle", 32'(cyc), 32'(lat + 2));
                first_resp = o_rresp;
                first_data = o_rdata;
            end
            ed = (exp_resp[b] == OKAY) ? mem[word_of(exp_addr[b])] : 32'd0;
            stall = int'($urandom_range(stall_hi, stall_lo));
            for (int s = 0; s <= stall; s++) begin
                check_beat(ed, exp_resp[b], b == int'(len), id);
                if (o_arready) busy_hi++;
                if (s == stall) rready = 1'b1;
                @(negedge clock);
                cyc++;
            end
            rready = 1'b0;
        end
        check("arready_busy", 32'(busy_hi), 32'd0);
        check("idle_rvalid", 32'(o_rvalid), 32'd0);
        check("idle_arready", 32'(o_arready), 32'd1);
        check("mem_read_count", 32'(memq.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size() && i < memq.size(); i++)
            check("mem_addr", 32'(memq[i]), 32'(exp_words[i]));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  resp;
        int          word;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fr;
        logic [31:0] fd, a;
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
        int r, nv, cyc;

        for (int i = 0; i < 65536; i++) mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
        mem[0] = 32'h0000_0413;

        vecs[0]  = '{32'h8000_0000, 4'h5, 8'd0, 3'd2, INCR,  OKAY,   0};
        vecs[1]  = '{32'h8000_0010, 4'h3, 8'd3, 3'd2, INCR,  OKAY,   4};
        vecs[2]  = '{32'h8000_000C, 4'h9, 8'd3, 3'd2, WRAP,  OKAY,   3};
        vecs[3]  = '{32'h8000_000C, 4'h1, 8'd2, 3'd2, WRAP,  SLVERR, -1};
        vecs[4]  = '{32'h0000_1000, 4'h2, 8'd1, 3'd2, INCR,  DECERR, -1};
        vecs[5]  = '{32'h8000_0040, 4'h4, 8'd0, 3'd2, INCR,  OKAY,   16};
        vecs[6]  = '{32'h8000_0000, 4'h6, 8'd1, 3'd3, INCR,  SLVERR, -1};
        vecs[7]  = '{32'h8000_0020, 4'h7, 8'd1, 3'd2, 2'b11, SLVERR, -1};
        vecs[8]  = '{32'h8003_FFF8, 4'h8, 8'd3, 3'd2, INCR,  OKAY,   32'hFFFE};
        vecs[9]  = '{32'h8004_0000, 4'hA, 8'd0, 3'd2, INCR,  DECERR, -1};
        vecs[10] = '{32'h7FFF_FFFC, 4'hB, 8'd0, 3'd2, INCR,  DECERR, -1};
        vecs[11] = '{32'h8000_0100, 4'hC, 8'd2, 3'd2, FIXED, OKAY,   32'h40};
        vecs[12] = '{32'h8000_0001, 4'hD, 8'd3, 3'd0, INCR,  OKAY,   0};
        vecs[13] = '{32'h8000_0036, 4'hE, 8'd7, 3'd1, WRAP,  OKAY,   13};

        reset = 1'b0; sel = 1'b0; arvalid = 1'b0; rready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        repeat (3) @(negedge clock);
        check("rst_arready", 32'(o_arready), 32'd0);
        check("rst_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_rlast", 32'(o_rlast), 32'd0);
        check("rst_mem_en", 32'(o_mem_en), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_rresp", 32'(o_rresp), 32'd0);
        check("rst_rid", 32'(o_rid), 32'd0);
        check("rst_arready_lat5", 32'(arready_5), 32'd0);
        reset = 1'b1;
        #1 check("arready_before_edge", 32'(o_arready), 32'd0);
        @(negedge clock);
        check("arready_after_release", 32'(o_arready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].size, vecs[i].burst,
                    0, 2, 0, fr, fd);
            check($sformatf("vec%0d_resp", i), 32'(fr), 32'(vecs[i].resp));
            check($sformatf("vec%0d_data", i), fd,
                  (vecs[i].word < 0) ? 32'd0 : mem[16'(vecs[i].word)]);
            if (i == 2 && memq.size() == 4) begin
                check("wrap_seq0", 32'(memq[0]), 32'd3);
                check("wrap_seq1", 32'(memq[1]), 32'd0);
                check("wrap_seq2", 32'(memq[2]), 32'd1);
                check("wrap_seq3", 32'(memq[3]), 32'd2);
            end
        end

        // Long rready stall: outputs frozen, no SRAM traffic.
        run_txn(32'h8000_0200, 4'h3, 8'd1, 3'd2, INCR, 30, 30, 0, fr, fd);
        check("long_stall_data", fd, mem[16'h80]);

        for (int t = 0; t < 40; t++) begin
            r = int'($urandom_range(7, 0));
            size = ($urandom_range(7, 0) == 0) ? 3'd3 : 3'($urandom_range(2, 0));
            if (r == 0) a = $urandom();
            else if (r == 1) a = BASE + BYTES - 32'(4 * $urandom_range(8, 1));
            else a = BASE + (32'($urandom_range(32'h3FFFF, 0)) & ~32'd3);
            if (size < 3'd2) a = a + 32'($urandom_range(3, 0));
            r = int'($urandom_range(9, 0));
            burst = (r == 0) ? 2'b11 : (r < 3) ? FIXED : (r < 5) ? WRAP : INCR;
            len = 8'($urandom_range(15, 0));
            if (burst == WRAP && $urandom_range(3, 0) != 0)
                len = 8'((2 << $urandom_range(3, 0)) - 1);
            run_txn(a, 4'($urandom()), len, size, burst, 0, 3, 0, fr, fd);
        end

        // Five-cycle latency instance.
        sel = 1'b1;
        run_txn(32'h8000_0080, 4'h6, 8'd0, 3'd2, INCR, 0, 0, 5, fr, fd);
        check("lat5_data", fd, mem[16'h20]);
        check("lat5_resp", 32'(fr), 32'(OKAY));
        for (int t = 0; t < 6; t++)
            run_txn(BASE + (32'($urandom_range(32'hFFFF, 0)) << 2), 4'($urandom()),
                    8'($urandom_range(7, 0)), 3'd2, INCR, 0, 2, 5, fr, fd);
        sel = 1'b0;

        // Reset during the second beat of an 8-beat burst.
        @(negedge clock);
        araddr = 32'h8000_0400; arid = 4'h9; arlen = 8'd7; arsize = 3'd2; arburst = INCR;
        arvalid = 1'b1; rready = 1'b1;
        @(negedge clock);
        arvalid = 1'b0;
        nv = 0;
        cyc = 0;
        while (nv < 2 && cyc < 100) begin
            if (o_rvalid) nv++;
            if (nv < 2) begin
                @(negedge clock);
                cyc++;
            end
        end
        check("mid_burst_reached_beat2", 32'(nv), 32'd2);
        reset = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(o_rvalid), 32'd0);
        check("mid_rst_arready", 32'(o_arready), 32'd0);
        check("mid_rst_mem_en", 32'(o_mem_en), 32'd0);
        rready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_rst_arready", 32'(o_arready), 32'd1);
        check("post_rst_rvalid", 32'(o_rvalid), 32'd0);
        run_txn(32'h8000_0500, 4'h2, 8'd3, 3'd2, INCR, 0, 1, 0, fr, fd);
        check("post_rst_data", fd, mem[16'h140]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_inst_mem_responder.md
Name: axi_inst_mem_responder

Overview:
- AXI4 read-only responder (slave) for the instruction-fetch path. Answers AR/R transactions issued by the ICache refill master.
- Backed by an external synchronous-read word SRAM with 1-cycle read latency.
- Adds a configurable per-transaction access delay to model slow memory in simulation.
- Sits between the ICache read master port and the instruction SRAM / boot image.

Parameters:
- BASE, 32'h80000000, byte address of SRAM word 0.
- DEPTH_LOG2, 16, log2 of SRAM depth in 32-bit words.
- LATENCY, 0, extra idle cycles inserted between AR handshake and the first SRAM read (0..255).
- ID_W, 4, width of arid/rid.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- araddr  in  32  burst start byte address.
- arid  in  ID_W  transaction ID.
- arlen  in  8  beats minus 1.
- arsize  in  3  log2 bytes per beat.
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- rdata  out  32  read data (full word, lane-aligned to address).
- rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- rlast  out  1  final beat.
- rid  out  ID_W  echoes the latched arid.
- mem_en  out  1  SRAM read enable.
- mem_addr  out  DEPTH_LOG2  SRAM word index.
- mem_rdata  in  32  SRAM data, valid the cycle after mem_en.

Behaviour:
- Reset (async, reset=0): state IDLE; arready, rvalid, rlast, mem_en = 0; rdata, rresp, rid = 0. arready rises on the first clock edge after reset deasserts.
- One outstanding transaction. No AR is accepted until the last R beat handshakes.
- IDLE:
  - arready=1.
  - On arvalid&arready: latch addr, len, size, burst, id; clear beat counter; classify resp.
  - Classification:
    - DECERR if araddr is outside [BASE, BASE+4<<DEPTH_LOG2).
    - Else SLVERR if arsize>2 or arburst==11.
    - Else SLVERR if arburst==WRAP and arlen not in {1,3,7,15}.
    - Else OKAY.
  - Next state is DELAY if LATENCY>0, else READ. arready drops the cycle after acceptance.
- DELAY: counter loads LATENCY and decrements each cycle; at 1, go to READ. Total delay is exactly LATENCY cycles.
- READ:
  - If resp==OKAY: mem_en=1 for one cycle, mem_addr=(addr-BASE)>>2.
  - Next state is RESP. On entry, rdata captures mem_rdata, or 0 if resp!=OKAY (no mem_en in that case).
- RESP:
  - rvalid=1; rdata, rresp, rid, rlast held stable until rready.
  - rlast=1 iff beat counter==len.
  - On handshake:
    - Final beat: go to IDLE.
    - Otherwise: increment beat counter, advance addr, go to READ.
  - Minimum 2 cycles per beat; the first beat arrives LATENCY+2 cycles after the AR handshake.
- Error bursts still return exactly len+1 beats, all with the same rresp.
- Address advance (32-bit wrap-around arithmetic), step = 1<<size:
  - FIXED: addr unchanged.
  - INCR: addr + step.
  - WRAP: lower bits wrap within a window of (len+1)*step aligned to that size; upper bits unchanged.
- Narrow sizes (0,1): the whole word is returned; the master selects lanes by address.
- An address advance that crosses the top of SRAM mid-INCR gives DECERR on that beat and all remaining beats of the burst.
- rready held low indefinitely: outputs stay frozen and no SRAM reads are issued.
- Reset asserted mid-burst: immediate return to IDLE with rvalid=0. The partial burst is abandoned and not resumed.

Decomposition:
- Shared package (ysyx AXI package): burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR/DECERR), and the state enum {IDLE, DELAY, READ, RESP}.
- Also in the package: a pure function next_beat_addr(addr, size, len, burst), reused by any future AXI master/slave.
- No sub-module is needed; the address generator is the package function.

Test Plan:
- LATENCY=0, mem[0]=0x00000413: AR addr 0x80000000 len0 size2 INCR.
  → rvalid in cycle 2 after AR, rdata=0x00000413, rresp=00, rlast=1, rid=arid.
- INCR, addr 0x80000010 len3 size2, rready toggling 1,0,0,1.
  → mem_addr sequence 4,5,6,7; data stable during stalls; rlast on beat 3 only.
- WRAP, addr 0x8000000C len3 size2.
  → word addresses 3,0,1,2. WRAP with len=2 → 3 beats of SLVERR, rdata=0, mem_en never high.
- AR addr 0x00001000 (out of range), len1.
  → 2 beats of DECERR, rdata=0, no mem_en. A following valid AR is accepted and returns OKAY.
- LATENCY=5, single beat.
  → first rvalid exactly 7 cycles after AR handshake; arready low from the cycle after acceptance until return to IDLE.
- Assert reset during beat 2 of a len7 burst.
  → rvalid=0 and arready=0 immediately; arready=1 one cycle after release; a new burst completes normally.
